// File: rtl/lrm_accum_if.sv
// Load-response beat / packed-register bus of the VPU load-result merger.
// slave is the merger side, master is the side that feeds beats and
// consumes packed registers.
interface lrm_accum_if #(
    parameter int DATA_W = 512
) ();
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [OFF_W-1:0]  in_src_off;
    logic [OFF_W-1:0]  in_dst_off;
    logic [OFF_W:0]    in_cnt;
    logic [2:0]        in_stride;
    logic [1:0]        in_eew;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [NB-1:0]     out_byte_en;
    logic              out_err;

    modport slave (
        input  in_valid, in_data, in_src_off, in_dst_off, in_cnt,
               in_stride, in_eew, in_last, out_ready,
        output in_ready, out_valid, out_data, out_byte_en, out_err
    );

    modport master (
        output in_valid, in_data, in_src_off, in_dst_off, in_cnt,
               in_stride, in_eew, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_byte_en, out_err
    );
endinterface

// File: rtl/lrm_accum.sv
// Multi-beat load-result merger: extracts strided elements from each load
// beat, packs them at a destination byte offset, accumulates beats into one
// register image with byte enables and presents it on the last beat.
module lrm_accum #(
    parameter int DATA_W = 512
) (
    input  logic        clk,
    input  logic        reset_n,
    lrm_accum_if.slave  bus
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    // Signed geometry width: large enough that no source/destination
    // address computation can wrap.
    localparam int AW    = OFF_W + 8;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    localparam logic signed [AW-1:0] ZERO_S      = '0;
    localparam logic signed [AW-1:0] ONE_S       = AW'(1);
    localparam logic signed [AW-1:0] LAST_BYTE_S = AW'(NB - 1);
    localparam logic signed [AW-1:0] NB_S        = AW'(NB);
    localparam logic [OFF_W:0]       NB_CNT      = (OFF_W + 1)'(NB);

    // Registered state and output image
    logic [0:0]        state_r;
    logic [DATA_W-1:0] data_r;
    logic [NB-1:0]     en_r;
    logic              err_r;

    // Handshake
    logic              out_valid_s;
    logic              accept_s;
    logic              xfer_s;

    // Beat geometry
    logic [OFF_W:0]         cnt_eff_s;
    logic [2:0]             step_sh_s;
    logic signed [AW-1:0]   elem_bytes_s;
    logic signed [AW-1:0]   src_base_s;
    logic signed [AW-1:0]   dst_base_s;
    logic signed [AW-1:0]   elem_src_s [NB];
    logic [NB-1:0]          elem_ok_s;
    logic                   src_drop_s;
    logic                   dst_drop_s;
    logic                   beat_err_s;

    // Beat write image and merge result
    logic [NB-1:0]     wr_en_s;
    logic [DATA_W-1:0] wr_data_s;
    logic [NB-1:0]     base_en_s;
    logic              base_err_s;
    logic [DATA_W-1:0] merged_data_s;
    logic [NB-1:0]     merged_en_s;
    logic              merged_err_s;

    assign out_valid_s     = (state_r == ST_HOLD);
    assign bus.in_ready    = !out_valid_s || bus.out_ready;
    assign accept_s        = bus.in_valid && bus.in_ready;
    assign xfer_s          = out_valid_s && bus.out_ready;

    assign bus.out_valid   = out_valid_s;
    assign bus.out_data    = data_r;
    assign bus.out_byte_en = en_r;
    assign bus.out_err     = err_r;

    // Beat geometry: clamped element count, log2 of the byte step between
    // elements, element size and signed base offsets.
    always_comb begin
        if (bus.in_cnt > NB_CNT) begin
            cnt_eff_s = NB_CNT;
        end else begin
            cnt_eff_s = bus.in_cnt;
        end
        step_sh_s    = {1'b0, bus.in_stride[1:0]} + {1'b0, bus.in_eew};
        elem_bytes_s = ONE_S << bus.in_eew;
        src_base_s   = $signed({{(AW - OFF_W){1'b0}}, bus.in_src_off});
        dst_base_s   = $signed({{(AW - OFF_W){1'b0}}, bus.in_dst_off});
    end

    // Per-element source start address and whole-element source range check
    always_comb begin
        logic signed [AW-1:0] step_v;
        logic signed [AW-1:0] last_v;
        src_drop_s = 1'b0;
        elem_ok_s  = '0;
        for (int k = 0; k < NB; k++) begin
            step_v = AW'(k) << step_sh_s;
            if (bus.in_stride[2]) begin
                elem_src_s[k] = src_base_s - step_v;
            end else begin
                elem_src_s[k] = src_base_s + step_v;
            end
            last_v = elem_src_s[k] + elem_bytes_s - ONE_S;
            if (k < int'(cnt_eff_s)) begin
                if ((elem_src_s[k] >= ZERO_S) && (last_v <= LAST_BYTE_S)) begin
                    elem_ok_s[k] = 1'b1;
                end else begin
                    elem_ok_s[k] = 1'b0;
                    src_drop_s   = 1'b1;
                end
            end else begin
                elem_ok_s[k] = 1'b0;
            end
        end
    end

    // Per-destination-byte gather: find the element and byte lane feeding
    // each destination byte; bytes past the register end are never reached
    // here, so their loss is flagged from the packed end address instead.
    always_comb begin
        logic signed [AW-1:0] end_v;
        logic signed [AW-1:0] rel_v;
        logic signed [AW-1:0] kk_v;
        logic signed [AW-1:0] src_v;
        logic [OFF_W-1:0]     k_idx_v;
        wr_en_s    = '0;
        wr_data_s  = '0;
        end_v      = dst_base_s + ($signed({{(AW - OFF_W - 1){1'b0}}, cnt_eff_s}) << bus.in_eew);
        dst_drop_s = (end_v > NB_S);
        for (int d = 0; d < NB; d++) begin
            rel_v   = AW'(d) - dst_base_s;
            kk_v    = rel_v >>> bus.in_eew;
            k_idx_v = kk_v[OFF_W-1:0];
            src_v   = ZERO_S;
            if (rel_v >= ZERO_S) begin
                if (elem_ok_s[k_idx_v]) begin
                    src_v                = elem_src_s[k_idx_v] + (rel_v & (elem_bytes_s - ONE_S));
                    wr_en_s[d]           = 1'b1;
                    wr_data_s[d*8 +: 8]  = bus.in_data[{src_v[OFF_W-1:0], 3'b000} +: 8];
                end else begin
                    wr_en_s[d] = 1'b0;
                end
            end else begin
                wr_en_s[d] = 1'b0;
            end
        end
    end

    // Merge the beat into the buffer; a completing transfer on the same
    // edge clears the enables and error so the old image is not mixed in.
    always_comb begin
        beat_err_s = src_drop_s || dst_drop_s;
        if (xfer_s) begin
            base_en_s  = '0;
            base_err_s = 1'b0;
        end else begin
            base_en_s  = en_r;
            base_err_s = err_r;
        end
        merged_data_s = data_r;
        for (int d = 0; d < NB; d++) begin
            if (wr_en_s[d]) begin
                merged_data_s[d*8 +: 8] = wr_data_s[d*8 +: 8];
            end else begin
                merged_data_s[d*8 +: 8] = data_r[d*8 +: 8];
            end
        end
        merged_en_s  = base_en_s | wr_en_s;
        merged_err_s = base_err_s || beat_err_s;
    end

    // Image buffer update: merge on accept, clear enables/error after a
    // transfer with no new beat, hold otherwise.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_r <= '0;
            en_r   <= '0;
            err_r  <= 1'b0;
        end else if (accept_s) begin
            data_r <= merged_data_s;
            en_r   <= merged_en_s;
            err_r  <= merged_err_s;
        end else if (xfer_s) begin
            en_r   <= '0;
            err_r  <= 1'b0;
        end else begin
            data_r <= data_r;
            en_r   <= en_r;
            err_r  <= err_r;
        end
    end

    // ACCUM/HOLD control: a last beat closes the register, a transfer
    // reopens it unless a new last beat lands on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_ACCUM;
        end else begin
            case (state_r)
                ST_ACCUM: begin
                    if (accept_s && bus.in_last) begin
                        state_r <= ST_HOLD;
                    end else begin
                        state_r <= ST_ACCUM;
                    end
                end
                ST_HOLD: begin
                    if (xfer_s && !(accept_s && bus.in_last)) begin
                        state_r <= ST_ACCUM;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r <= ST_ACCUM;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lrm_accum.sv
// Directed bench for lrm_accum with DATA_W=512 (NB=64).
module tb_lrm_accum;
    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] d;
    int            total = 0;
    int            bad   = 0;

    always #5 clk = ~clk;

    lrm_accum_if #(.DATA_W(DW)) bus ();

    lrm_accum #(.DATA_W(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [DW-1:0] data, input int src, input int dst,
                            input int cnt, input int stride, input int eew, input logic last);
        bus.in_data    = data;
        bus.in_src_off = 6'(src);
        bus.in_dst_off = 6'(dst);
        bus.in_cnt     = 7'(cnt);
        bus.in_stride  = 3'(stride);
        bus.in_eew     = 2'(eew);
        bus.in_last    = last;
        bus.in_valid   = 1'b1;
    endtask

    task automatic send(input logic [DW-1:0] data, input int src, input int dst,
                        input int cnt, input int stride, input int eew, input logic last);
        set_beat(data, src, dst, cnt, stride, eew, last);
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [63:0] en, input logic err);
        chk({tag, ".valid"}, DW'(bus.out_valid), DW'(1'b1));
        chk({tag, ".en"}, DW'(bus.out_byte_en), DW'(en));
        chk({tag, ".err"}, DW'(bus.out_err), DW'(err));
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_last    = 1'b0;
        bus.in_data    = '0;
        bus.in_src_off = 6'd0;
        bus.in_dst_off = 6'd0;
        bus.in_cnt     = 7'd0;
        bus.in_stride  = 3'd0;
        bus.in_eew     = 2'd0;
        bus.out_ready  = 1'b1;
        reset_n        = 1'b0;
        step();
        step();
        chk("rst.valid", DW'(bus.out_valid), DW'(1'b0));
        chk("rst.data", bus.out_data, '0);
        chk("rst.en", DW'(bus.out_byte_en), '0);
        chk("rst.err", DW'(bus.out_err), '0);
        chk("rst.in_ready", DW'(bus.in_ready), DW'(1'b1));
        reset_n = 1'b1;

        // unit stride
        d = '0; d[31:0] = 32'h03020100;
        send(d, 0, 0, 4, 0, 0, 1'b1);
        chk_reg("unit", 64'hF, 1'b0);
        chk("unit.data", DW'(bus.out_data[31:0]), DW'(32'h03020100));

        // stride -1, bytes gathered downward from byte 63
        d = '0; d[511:480] = 32'h00010203;
        send(d, 63, 0, 4, 4, 0, 1'b1);
        chk_reg("neg1", 64'hF, 1'b0);
        chk("neg1.data", DW'(bus.out_data[31:0]), DW'(32'h03020100));

        // stride -2 halfwords: elements at bytes 62,58,54,50 -> dst bytes 4..11
        d = '0; d[511:384] = 128'h0000ffff0001ffff0002ffff0003ffff;
        send(d, 62, 4, 4, 5, 1, 1'b1);
        chk_reg("neg2", 64'hFF0, 1'b0);
        chk("neg2.data", DW'(bus.out_data[95:32]), DW'(64'h0003000200010000));

        // stride +8 halfwords: elements at bytes 0,16,32,48
        d = '0; d[15:0] = 16'h0000; d[143:128] = 16'h0001; d[271:256] = 16'h0002; d[399:384] = 16'h0003;
        send(d, 0, 0, 4, 3, 1, 1'b1);
        chk_reg("pos8", 64'hFF, 1'b0);
        chk("pos8.data", DW'(bus.out_data[63:0]), DW'(64'h0003000200010000));

        // two-beat accumulate (first beat merges into a cleared buffer)
        d = '0; d[15:0] = 16'hBBAA;
        send(d, 0, 0, 2, 0, 0, 1'b0);
        chk("acc.beat1_valid", DW'(bus.out_valid), DW'(1'b0));
        d = '0; d[15:0] = 16'hDDCC;
        send(d, 0, 2, 2, 0, 0, 1'b1);
        chk_reg("acc", 64'hF, 1'b0);
        chk("acc.data", DW'(bus.out_data[31:0]), DW'(32'hDDCCBBAA));

        // backpressure: new last beat presented but blocked for 3 cycles
        bus.out_ready = 1'b0;
        d = '0; d[7:0] = 8'h5A;
        set_beat(d, 0, 40, 1, 0, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_reg("bp", 64'hF, 1'b0);
            chk("bp.data", DW'(bus.out_data[31:0]), DW'(32'hDDCCBBAA));
            chk("bp.in_ready", DW'(bus.in_ready), DW'(1'b0));
        end
        bus.out_ready = 1'b1;
        #1;
        chk("b2b.in_ready", DW'(bus.in_ready), DW'(1'b1));
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk_reg("b2b", 64'h0000_0100_0000_0000, 1'b0);
        chk("b2b.data", DW'(bus.out_data[327:320]), DW'(8'h5A));

        // transfer with no new beat returns to accumulation
        step();
        chk("idle.valid", DW'(bus.out_valid), DW'(1'b0));

        // destination overrun: bytes 64,65 dropped
        d = '0; d[31:0] = 32'h44332211;
        send(d, 0, 62, 4, 0, 0, 1'b1);
        chk_reg("dstovr", 64'hC000_0000_0000_0000, 1'b1);
        chk("dstovr.data", DW'(bus.out_data[511:496]), DW'(16'h2211));

        // source underrun with stride -1: third element at byte -1 dropped
        d = '0; d[15:0] = 16'h2211;
        send(d, 1, 0, 3, 4, 0, 1'b1);
        chk_reg("srcneg", 64'h3, 1'b1);
        chk("srcneg.data", DW'(bus.out_data[15:0]), DW'(16'h1122));

        // halfword straddling the top of the source: whole element dropped
        d = '0;
        send(d, 63, 0, 1, 0, 1, 1'b1);
        chk_reg("srcstr", 64'h0, 1'b1);

        // doubleword element
        d = '0; d[127:64] = 64'h0123456789ABCDEF;
        send(d, 8, 0, 1, 0, 3, 1'b1);
        chk_reg("eew3", 64'hFF, 1'b0);
        chk("eew3.data", DW'(bus.out_data[63:0]), DW'(64'h0123456789ABCDEF));

        // zero-count last beat still completes the register
        send(d, 0, 0, 0, 0, 0, 1'b1);
        chk_reg("cnt0", 64'h0, 1'b0);

        // count above NB is clamped to NB
        for (int i = 0; i < 64; i++) d[i*8 +: 8] = 8'(i + 16);
        send(d, 0, 0, 100, 0, 0, 1'b1);
        chk_reg("cntbig", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        chk("cntbig.data", bus.out_data, d);

        // sticky error and last writer wins
        d = '0; d[31:0] = 32'hDDCCBBAA;
        send(d, 0, 62, 4, 0, 0, 1'b0);
        d = '0; d[7:0] = 8'h77;
        send(d, 0, 62, 1, 0, 0, 1'b1);
        chk_reg("lww", 64'hC000_0000_0000_0000, 1'b1);
        chk("lww.data", DW'(bus.out_data[511:496]), DW'(16'hBB77));

        // reset discards a partial accumulation
        d = '0; d[7:0] = 8'h11;
        send(d, 0, 0, 1, 0, 0, 1'b0);
        reset_n = 1'b0;
        step();
        chk("rst2.valid", DW'(bus.out_valid), DW'(1'b0));
        chk("rst2.en", DW'(bus.out_byte_en), '0);
        reset_n = 1'b1;
        d = '0; d[7:0] = 8'h22;
        send(d, 0, 1, 1, 0, 0, 1'b1);
        chk_reg("rst2", 64'h2, 1'b0);
        chk("rst2.data", DW'(bus.out_data[15:8]), DW'(8'h22));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
